hwag_channel: RTL and testbench
===============================

# hwag_channel

Angle-driven output channel bank that sits directly downstream of the hardware angle generator core. It consumes the 24-bit synchronized angle count (0..3839, 64 angle steps per tooth, 60-tooth wheel) and the sync flag. It drives CH outputs, each high between a programmable set angle and reset angle. Angles are programmed through a simple write port and double-buffered, so a window is never torn mid-pulse.

## Interface
- CH, 4, number of output channels (1..16)
- ANGLE_W, 24, width of angle count and angle registers
- ACNT_TOP, 3839, last angle value of a revolution (wraps to 0)
- clk  input  1  module clock
- rst  input  1  asynchronous reset, active-high
- hwag_start  input  1  angle generator synchronized
- acnt  input  ANGLE_W  current angle count from generator core
- wr_ena  input  1  write strobe, one register per cycle
- wr_addr  input  4  channel index; writes with wr_addr >= CH are ignored
- wr_sel  input  2  0 = set angle, 1 = reset angle, 2 = enable (wr_data[0]), 3 = ignored
- wr_data  input  ANGLE_W  write data
- ch_out  output  CH  channel outputs
- ch_miss  output  CH  one-cycle pulse: a window was skipped (set and reset crossed in one step)

## Operation
- Front end:
  - acnt_q <= acnt each cycle; acnt_p <= acnt_q.
  - step = (acnt_q != acnt_p) & hwag_start.
  - wrap = step & (acnt_p == ACNT_TOP) & (acnt_q == 0).
  - fwd = step & (acnt_q > acnt_p).
  - Any other step with acnt_q < acnt_p is a backward re-sync correction and generates no events.
- crossed(x):
  - on fwd: acnt_p < x <= acnt_q.
  - on wrap: x == 0.
  - x > ACNT_TOP is never crossed, so the channel never fires.
- Per channel registers:
  - pending set/rst/en, written by the port at any time.
  - active set/rst/en, used for comparison.
- Pending-to-active copy occurs in every cycle in which the channel is not ACTIVE and no set crossing occurs. A write made during ACTIVE takes effect after the window closes.
- Per channel FSM, states OFF / WAIT / ACTIVE:
  - Any state, hwag_start==0 or active en==0: next OFF, ch_out 0. Has priority over all other transitions.
  - OFF -> WAIT when hwag_start & active en.
  - WAIT -> ACTIVE on crossed(set) & !crossed(rst); ch_out <= 1.
  - WAIT: crossed(set) & crossed(rst) in the same step -> stay WAIT, ch_miss pulse, ch_out stays 0.
  - ACTIVE -> WAIT on crossed(rst); ch_out <= 0.
  - ACTIVE: crossed(set) is ignored.
- set == rst: the channel never goes ACTIVE. A crossing there yields ch_miss.
- set > rst: the window spans the wrap; it is valid and needs no special case.
- ch_out is a registered copy of (state == ACTIVE).

## Timing
- Reset values: ch_out = 0, ch_miss = 0, all FSMs OFF, acnt_q = acnt_p = 0, pending/active angles = 0, en = 0.
- Latency: acnt presenting a crossing value at cycle N gives ch_out change at the rising edge ending cycle N+2. Fixed 2-clock latency.
- Write latency:
  - A pending register is updated on the edge with wr_ena.
  - It becomes active on the next eligible edge, at the earliest 1 cycle later.
- hwag_start deassert: ch_out low at the 2nd edge after deassert, since hwag_start is sampled alongside acnt_q.
- All channels are evaluated in parallel; no inter-channel priority.

## Test plan
- Basic window:
  - Stimulus: ch0 set=128, rst=256, en=1; hwag_start=1; acnt ramps 0..3839 by 1 every 4 clocks.
  - Required: ch_out[0] rises 2 clocks after acnt=128 and falls 2 clocks after acnt=256; exactly one pulse per revolution.
- Wrap window:
  - Stimulus: ch1 set=3800, rst=40.
  - Required: high from 3800 through the 3839->0 wrap, low at 40.
  - Stimulus: backward correction 200->195.
  - Required: no event.
- Forward jump:
  - Stimulus: ch2 set=500, rst=600; acnt jumps 490->510.
  - Required: ch_out[2] rises.
  - Stimulus: jump 490->610 instead.
  - Required: ch_miss[2] single pulse, ch_out[2] stays 0.
- Shadowed write:
  - Stimulus: while ch0 ACTIVE (acnt=200), write rst=1000.
  - Required: the current pulse still ends at 256; the next revolution pulse spans 128..1000.
- Sync loss:
  - Stimulus: drop hwag_start while ch0 high at acnt=200.
  - Required: ch_out[0] 0 within 2 clocks; no output until hwag_start returns and the next set crossing occurs.
- Async reset:
  - Stimulus: assert rst mid-pulse.
  - Required: all ch_out 0 immediately; en cleared; no output after release until reprogrammed.

Source files
------------

// File: rtl/hwag_channel.sv
// rtl/hwag_channel.sv - angle-window output channel bank driven by the HWAG angle count
// Each channel is high between a double-buffered set and reset angle.
module hwag_channel #(
  parameter int CH       = 4,
  parameter int ANGLE_W  = 24,
  parameter int ACNT_TOP = 3839
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hwag_start,
  input  logic [ANGLE_W-1:0] acnt,
  input  logic               wr_ena,
  input  logic [3:0]         wr_addr,
  input  logic [1:0]         wr_sel,
  input  logic [ANGLE_W-1:0] wr_data,
  output logic [CH-1:0]      ch_out,
  output logic [CH-1:0]      ch_miss
);

  localparam logic [ANGLE_W-1:0] TOP = ANGLE_W'(ACNT_TOP);

  typedef enum logic [1:0] {S_OFF, S_WAIT, S_ACTIVE} state_t;

  logic [ANGLE_W-1:0] acnt_q, acnt_p;
  logic               hs_q;
  logic               step, wrap, fwd;

  // hwag_start is sampled alongside acnt_q so sync and angle stay aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acnt_q <= '0;
      acnt_p <= '0;
      hs_q   <= 1'b0;
    end else begin
      acnt_q <= acnt;
      acnt_p <= acnt_q;
      hs_q   <= hwag_start;
    end
  end

  assign step = hs_q && (acnt_q != acnt_p);
  assign wrap = step && (acnt_p == TOP) && (acnt_q == '0);
  assign fwd  = step && (acnt_q > acnt_p);

  function automatic logic crossed(input logic [ANGLE_W-1:0] x,
                                   input logic [ANGLE_W-1:0] lo,
                                   input logic [ANGLE_W-1:0] hi,
                                   input logic f,
                                   input logic w);
    if (x > TOP) return 1'b0;
    return (w && (x == '0)) || (f && (lo < x) && (x <= hi));
  endfunction

  genvar i;
  generate
    for (i = 0; i < CH; i++) begin : g_ch
      logic [ANGLE_W-1:0] p_set, p_rst, a_set, a_rst;
      logic               p_en, a_en;
      state_t             state, state_nxt;
      logic               x_set, x_rst, miss_nxt, out_r, miss_r, wr_hit;

      assign wr_hit = wr_ena && (wr_addr == 4'(i));
      assign x_set  = crossed(a_set, acnt_p, acnt_q, fwd, wrap);
      assign x_rst  = crossed(a_rst, acnt_p, acnt_q, fwd, wrap);

      // Active copy is frozen while the window is open or about to open
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p_set <= '0;
          p_rst <= '0;
          p_en  <= 1'b0;
          a_set <= '0;
          a_rst <= '0;
          a_en  <= 1'b0;
        end else begin
          if (wr_hit) begin
            case (wr_sel)
              2'd0:    p_set <= wr_data;
              2'd1:    p_rst <= wr_data;
              2'd2:    p_en  <= wr_data[0];
              default: ;
            endcase
          end
          if ((state != S_ACTIVE) && !x_set) begin
            a_set <= p_set;
            a_rst <= p_rst;
            a_en  <= p_en;
          end
        end
      end

      always_comb begin
        state_nxt = state;
        miss_nxt  = 1'b0;
        if (!hs_q || !a_en) begin
          state_nxt = S_OFF;
        end else begin
          case (state)
            S_OFF:  state_nxt = S_WAIT;
            S_WAIT: begin
              if (x_set && !x_rst) state_nxt = S_ACTIVE;
              else if (x_set && x_rst) miss_nxt = 1'b1;
            end
            S_ACTIVE: if (x_rst) state_nxt = S_WAIT;
            default: state_nxt = S_OFF;
          endcase
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state  <= S_OFF;
          out_r  <= 1'b0;
          miss_r <= 1'b0;
        end else begin
          state  <= state_nxt;
          out_r  <= (state_nxt == S_ACTIVE);
          miss_r <= miss_nxt;
        end
      end

      assign ch_out[i]  = out_r;
      assign ch_miss[i] = miss_r;
    end
  endgenerate

endmodule

// File: tb/tb_hwag_channel.sv
// tb/tb_hwag_channel.sv - self-checking bench for hwag_channel
// Cycle-level reference model plus directed scenario checks and random traffic.
module tb_hwag_channel;
  localparam int CH  = 4;
  localparam int TOP = 3839;

  logic          clk = 1'b0, rst = 1'b1, hwag_start = 1'b0;
  logic [23:0]   acnt = '0;
  logic          wr_ena = 1'b0;
  logic [3:0]    wr_addr = '0;
  logic [1:0]    wr_sel = '0;
  logic [23:0]   wr_data = '0;
  logic [CH-1:0] ch_out, ch_miss;

  hwag_channel dut (
    .clk(clk), .rst(rst), .hwag_start(hwag_start), .acnt(acnt),
    .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_sel(wr_sel), .wr_data(wr_data),
    .ch_out(ch_out), .ch_miss(ch_miss)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, cyc = 0;

  // reference model: previous two sampled angles, sync flag, per-channel program and mode
  int m_q, m_p;
  bit m_hs;
  int m_pset[CH], m_prst[CH], m_aset[CH], m_arst[CH], m_mode[CH];
  bit m_pen[CH], m_aen[CH];
  logic [CH-1:0] m_out, m_miss;

  logic [CH-1:0] prev_out, miss_acc;
  int rise_cnt[CH], fall_cnt[CH], miss_cnt[CH], rise_cyc[CH], fall_cyc[CH];

  task automatic model_reset();
    m_q = 0; m_p = 0; m_hs = 0; m_out = '0; m_miss = '0;
    for (int i = 0; i < CH; i++) begin
      m_pset[i] = 0; m_prst[i] = 0; m_aset[i] = 0; m_arst[i] = 0;
      m_pen[i] = 0; m_aen[i] = 0; m_mode[i] = 0;
    end
  endtask

  function automatic bit mcross(int x, int p, int q, bit fw, bit wr);
    if (x > TOP) return 0;
    if (wr) return x == 0;
    if (fw) return (p < x) && (x <= q);
    return 0;
  endfunction

  task automatic model_edge(int a_in, bit hs_in, bit we, int wa, int ws, int wd);
    bit stp, wr, fw, xs, xr;
    int old;
    stp = m_hs && (m_q != m_p);
    wr  = stp && (m_p == TOP) && (m_q == 0);
    fw  = stp && (m_q > m_p);
    for (int i = 0; i < CH; i++) begin
      xs = mcross(m_aset[i], m_p, m_q, fw, wr);
      xr = mcross(m_arst[i], m_p, m_q, fw, wr);
      old = m_mode[i];
      m_miss[i] = 1'b0;
      if (!m_hs || !m_aen[i]) m_mode[i] = 0;
      else if (old == 0) m_mode[i] = 1;
      else if (old == 1) begin
        if (xs && !xr) m_mode[i] = 2;
        else if (xs && xr) m_miss[i] = 1'b1;
      end else if (xr) m_mode[i] = 1;
      m_out[i] = (m_mode[i] == 2);
      if (old != 2 && !xs) begin
        m_aset[i] = m_pset[i]; m_arst[i] = m_prst[i]; m_aen[i] = m_pen[i];
      end
    end
    if (we && wa < CH) begin
      if (ws == 0) m_pset[wa] = wd;
      else if (ws == 1) m_prst[wa] = wd;
      else if (ws == 2) m_pen[wa] = wd[0];
    end
    m_p = m_q; m_q = a_in; m_hs = hs_in;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < CH; i++) begin
      rise_cnt[i] = 0; fall_cnt[i] = 0; miss_cnt[i] = 0; rise_cyc[i] = -1; fall_cyc[i] = -1;
    end
    miss_acc = '0;
  endtask

  task automatic tick();
    int a, wa, ws, wd;
    bit h, we;
    a = acnt; h = hwag_start; we = wr_ena; wa = wr_addr; ws = wr_sel; wd = wr_data;
    @(posedge clk);
    model_edge(a, h, we, wa, ws, wd);
    cyc++;
    #1;
    n_checks++;
    if (ch_out !== m_out) $display("FAIL model_ch_out cyc=%0d acnt=%0d got=%b exp=%b", cyc, a, ch_out, m_out);
    else n_pass++;
    n_checks++;
    if (ch_miss !== m_miss) $display("FAIL model_ch_miss cyc=%0d acnt=%0d got=%b exp=%b", cyc, a, ch_miss, m_miss);
    else n_pass++;
    for (int i = 0; i < CH; i++) begin
      if (ch_out[i] === 1'b1 && prev_out[i] === 1'b0) begin rise_cnt[i]++; rise_cyc[i] = cyc; end
      if (ch_out[i] === 1'b0 && prev_out[i] === 1'b1) begin fall_cnt[i]++; fall_cyc[i] = cyc; end
      if (ch_miss[i] === 1'b1) miss_cnt[i]++;
    end
    prev_out = ch_out;
    miss_acc |= ch_miss;
  endtask

  task automatic wr(int a, int s, int d);
    wr_ena = 1'b1; wr_addr = 4'(a); wr_sel = 2'(s); wr_data = 24'(d);
    tick();
    wr_ena = 1'b0;
  endtask

  task automatic setv(int v, int n);
    acnt = 24'(v);
    repeat (n) tick();
  endtask

  task automatic ramp(int lo, int hi, int hold, int m1, int m2, output int c1, output int c2);
    c1 = -1; c2 = -1;
    for (int v = lo; v <= hi; v++) begin
      acnt = 24'(v);
      if (v == m1) c1 = cyc;
      if (v == m2) c2 = cyc;
      repeat (hold) tick();
    end
  endtask

  task automatic ramp_plain(int lo, int hi, int hold);
    int d1, d2;
    ramp(lo, hi, hold, -1, -1, d1, d2);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ch_out !== '0) $display("FAIL reset_ch_out got=%b exp=0", ch_out); else n_pass++;
    n_checks++; if (ch_miss !== '0) $display("FAIL reset_ch_miss got=%b exp=0", ch_miss); else n_pass++;
    rst = 1'b0;
    model_reset();
    prev_out = '0;
    clear_counts();
    repeat (2) tick();
  endtask

  task automatic test_basic();
    int c1, c2;
    wr(0, 0, 128); wr(0, 1, 256); wr(0, 2, 1);
    hwag_start = 1'b1;
    setv(0, 4);
    clear_counts();
    ramp(0, TOP, 4, 128, 256, c1, c2);
    setv(0, 4);
    n_checks++; if (rise_cnt[0] != 1) $display("FAIL basic_pulse_count got=%0d exp=1", rise_cnt[0]); else n_pass++;
    n_checks++; if (rise_cyc[0] - c1 != 2) $display("FAIL basic_rise_latency got=%0d exp=2", rise_cyc[0] - c1); else n_pass++;
    n_checks++; if (fall_cyc[0] - c2 != 2) $display("FAIL basic_fall_latency got=%0d exp=2", fall_cyc[0] - c2); else n_pass++;
    n_checks++; if (ch_out[0] !== 1'b0) $display("FAIL basic_idle_low got=%b exp=0", ch_out[0]); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [CH-1:0] snap;
    clear_counts();
    wr(1, 0, 3800); wr(1, 1, 40); wr(1, 2, 1);
    setv(3790, 3);
    ramp_plain(3791, TOP, 2);
    n_checks++; if (ch_out[1] !== 1'b1) $display("FAIL wrap_high_before got=%b exp=1", ch_out[1]); else n_pass++;
    ramp_plain(0, 30, 2);
    n_checks++; if (ch_out[1] !== 1'b1) $display("FAIL wrap_high_after got=%b exp=1", ch_out[1]); else n_pass++;
    ramp_plain(31, 50, 2);
    n_checks++; if (ch_out[1] !== 1'b0) $display("FAIL wrap_low_at_40 got=%b exp=0", ch_out[1]); else n_pass++;
    n_checks++; if (rise_cnt[1] != 1) $display("FAIL wrap_pulse_count got=%0d exp=1", rise_cnt[1]); else n_pass++;
    setv(200, 3);
    snap = ch_out;
    miss_acc = '0;
    setv(195, 4);
    n_checks++; if (ch_out !== snap) $display("FAIL backward_no_event got=%b exp=%b", ch_out, snap); else n_pass++;
    n_checks++; if (miss_acc !== '0) $display("FAIL backward_no_miss got=%b exp=0", miss_acc); else n_pass++;
  endtask

  task automatic test_forward_jump();
    wr(2, 0, 500); wr(2, 1, 600); wr(2, 2, 1);
    setv(490, 3);
    setv(510, 3);
    n_checks++; if (ch_out[2] !== 1'b1) $display("FAIL jump_rise got=%b exp=1", ch_out[2]); else n_pass++;
    setv(610, 3);
    setv(490, 3);
    clear_counts();
    setv(610, 4);
    n_checks++; if (miss_cnt[2] != 1) $display("FAIL jump_miss_pulses got=%0d exp=1", miss_cnt[2]); else n_pass++;
    n_checks++; if (rise_cnt[2] != 0 || ch_out[2] !== 1'b0) $display("FAIL jump_miss_no_out got=%0d/%b exp=0/0", rise_cnt[2], ch_out[2]); else n_pass++;
  endtask

  task automatic test_shadowed_write();
    int c1, c2;
    setv(TOP, 2);
    setv(0, 1);
    ramp_plain(0, 200, 1);
    n_checks++; if (ch_out[0] !== 1'b1) $display("FAIL shadow_active got=%b exp=1", ch_out[0]); else n_pass++;
    wr(0, 1, 1000);
    clear_counts();
    ramp(201, TOP, 1, 256, -1, c1, c2);
    n_checks++; if (fall_cyc[0] - c1 != 2) $display("FAIL shadow_old_end got=%0d exp=2", fall_cyc[0] - c1); else n_pass++;
    setv(0, 1);
    clear_counts();
    ramp(0, 1100, 1, 128, 1000, c1, c2);
    n_checks++; if (rise_cyc[0] - c1 != 2) $display("FAIL shadow_new_start got=%0d exp=2", rise_cyc[0] - c1); else n_pass++;
    n_checks++; if (fall_cyc[0] - c2 != 2) $display("FAIL shadow_new_end got=%0d exp=2", fall_cyc[0] - c2); else n_pass++;
  endtask

  task automatic test_sync_loss();
    int rc;
    setv(TOP, 1);
    setv(0, 1);
    ramp_plain(0, 200, 1);
    n_checks++; if (ch_out[0] !== 1'b1) $display("FAIL sync_pre_high got=%b exp=1", ch_out[0]); else n_pass++;
    hwag_start = 1'b0;
    repeat (2) tick();
    n_checks++; if (ch_out[0] !== 1'b0) $display("FAIL sync_drop_low got=%b exp=0", ch_out[0]); else n_pass++;
    rc = rise_cnt[0];
    ramp_plain(201, 400, 1);
    hwag_start = 1'b1;
    ramp_plain(401, 1100, 1);
    n_checks++; if (rise_cnt[0] != rc || ch_out[0] !== 1'b0) $display("FAIL sync_no_output got=%0d/%b exp=%0d/0", rise_cnt[0], ch_out[0], rc); else n_pass++;
    setv(TOP, 1);
    setv(0, 1);
    ramp_plain(0, 200, 1);
    n_checks++; if (ch_out[0] !== 1'b1) $display("FAIL sync_resume got=%b exp=1", ch_out[0]); else n_pass++;
  endtask

  task automatic test_async_reset();
    int tot;
    rst = 1'b1;
    #1;
    n_checks++; if (ch_out !== '0) $display("FAIL areset_immediate got=%b exp=0", ch_out); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    prev_out = '0;
    clear_counts();
    ramp_plain(201, TOP, 1);
    setv(0, 1);
    ramp_plain(0, 300, 1);
    tot = 0;
    for (int i = 0; i < CH; i++) tot += rise_cnt[i] + miss_cnt[i];
    n_checks++; if (tot != 0 || ch_out !== '0) $display("FAIL areset_en_cleared got=%0d/%b exp=0/0", tot, ch_out); else n_pass++;
  endtask

  function automatic int rand_angle();
    int r;
    r = $urandom_range(99);
    if (r < 5) return TOP + 1 + $urandom_range(100);
    if (r < 10) return 0;
    return $urandom_range(TOP);
  endfunction

  task automatic test_random();
    int r, cur, s;
    for (int i = 0; i < CH; i++) begin
      wr(i, 0, rand_angle()); wr(i, 1, rand_angle()); wr(i, 2, 1);
    end
    wr(3, 0, 300); wr(3, 1, 300);
    hwag_start = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(99);
      cur = acnt;
      if (r < 65) begin
        s = $urandom_range(40, 1);
        if (cur + s > TOP) acnt = (cur == TOP) ? 24'd0 : 24'(TOP);
        else acnt = 24'(cur + s);
        tick();
      end else if (r < 70) begin
        if (cur > 10) acnt = 24'(cur - $urandom_range(10, 1));
        tick();
      end else if (r < 75) begin
        acnt = 24'($urandom_range(TOP));
        tick();
      end else if (r < 80) begin
        tick();
      end else if (r < 96) begin
        wr($urandom_range(15), $urandom_range(3), ($urandom_range(3) == 0) ? 1 : rand_angle());
      end else begin
        hwag_start = ~hwag_start;
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_forward_jump();
    test_shadowed_write();
    test_sync_loss();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
